// File: rtl/ram_mp_arbiter.sv
// ram_mp_arbiter: round-robin NUM_CH-to-1 front-end for the shared RAM port.
// Define RAM_ARB_CHK_EN to reject misaligned or REN&WEN requests locally.
package ram_pkg;
   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;
endpackage

module ram_mp_arbiter
   import ram_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [NUM_CH-1:0]        memREN,
   input  logic [NUM_CH-1:0]        memWEN,
   input  logic [NUM_CH*ADDR_W-1:0] memaddr,
   input  logic [NUM_CH*DATA_W-1:0] memstore,
   output logic [NUM_CH*2-1:0]      ramstate,
   output logic [NUM_CH*DATA_W-1:0] ramload,
   output logic                     ramREN,
   output logic                     ramWEN,
   output logic [ADDR_W-1:0]        ramaddr,
   output logic [DATA_W-1:0]        ramstore,
   input  logic [1:0]               ram_state,
   input  logic [DATA_W-1:0]        ram_load
);
   localparam int CH_W = $clog2(NUM_CH);
   localparam int TM_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} fsm_t;

   fsm_t              state_q;
   fsm_t              state_d;
   logic [CH_W-1:0]   rr_q;
   logic [CH_W-1:0]   grant_q;
   logic [CH_W-1:0]   pick;
   logic              found;
   int                idx;
   logic [TM_W-1:0]   timer_q;
   logic              wr_q;
   logic              keep_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] store_q;
   logic [DATA_W-1:0] load_q [NUM_CH];
   logic [NUM_CH-1:0] req;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_store;
   logic              bad;
   ramstate_t         st [NUM_CH];

   assign req = memREN | memWEN;

   // later hits overwrite earlier ones, so the lowest offset from rr_q wins
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % NUM_CH;
         if (req[idx]) begin
            pick  = CH_W'(idx);
            found = 1'b1;
         end
      end
   end

   assign sel_addr  = memaddr[int'(pick)*ADDR_W +: ADDR_W];
   assign sel_store = memstore[int'(pick)*DATA_W +: DATA_W];

`ifdef RAM_ARB_CHK_EN
   assign bad = (sel_addr[1:0] != 2'b00) || (memREN[pick] && memWEN[pick]);
`else
   assign bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (found) state_d = bad ? ERR : WAIT;
         WAIT: begin
            if (ram_state == ACCESS)
               state_d = DONE;
            else if (ram_state == ERROR || timer_q == TM_W'(TIMEOUT - 1))
               state_d = ERR;
         end
         DONE, ERR: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         timer_q <= '0;
         wr_q    <= 1'b0;
         keep_q  <= 1'b0;
         addr_q  <= '0;
         store_q <= '0;
         for (int i = 0; i < NUM_CH; i++) load_q[i] <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (found) begin
                  grant_q <= pick;
                  wr_q    <= memWEN[pick];
                  addr_q  <= sel_addr;
                  store_q <= sel_store;
                  timer_q <= '0;
                  keep_q  <= 1'b1;
               end
            end
            WAIT: begin
               timer_q <= timer_q + TM_W'(1);
               // a requester that let go before completion gets nothing back
               if (state_d != WAIT) keep_q <= req[grant_q];
               if (state_d == DONE && !wr_q && req[grant_q])
                  load_q[grant_q] <= ram_load;
            end
            DONE, ERR: rr_q <= CH_W'((int'(grant_q) + 1) % NUM_CH);
            default: ;
         endcase
      end
   end

   assign ramREN   = (state_q == WAIT) && !wr_q;
   assign ramWEN   = (state_q == WAIT) && wr_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         st[i] = (nRST && req[i]) ? BUSY : FREE;
         if (keep_q && CH_W'(i) == grant_q) begin
            if (state_q == DONE) st[i] = ACCESS;
            if (state_q == ERR)  st[i] = ERROR;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign ramstate[g*2 +: 2]          = st[g];
      assign ramload[g*DATA_W +: DATA_W] = load_q[g];
   end

endmodule
